product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulate stage that sits directly downstream of the signed array multiplier. It consumes a stream of 2N-bit two's-complement products over a valid/ready handshake and sums TERMS consecutive products into a saturating ACC_W-bit accumulator. It then presents each completed sum (a dot-product result) with a sticky overflow flag on an output valid/ready handshake.

## Interface
- N, default 4: operand width of the upstream multiplier; products are 2N bits.
- TERMS, default 4: products per result; legal range 2..255.
- ACC_W, default 12: accumulator/result width; must satisfy ACC_W >= 2N.
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prod  in  2N  signed two's-complement product from the multiplier.
- in_valid  in  1  prod is valid this cycle.
- in_ready  out  1  block accepts prod this cycle.
- clear  in  1  synchronous abort: discard the partial sum and restart the term count.
- result  out  ACC_W  signed accumulated sum.
- ovf  out  1  saturation occurred at any point while forming this result.
- out_valid  out  1  result/ovf valid.
- out_ready  in  1  consumer accepts result this cycle.

## Operation
- States: ACCUM and DONE. Reset enters ACCUM with acc=0, count=0, ovf_sticky=0.
- ACCUM: in_ready=1, out_valid=0. An input is accepted when in_valid && in_ready.
- On accept: acc <= sat(acc + sext(prod)) and count <= count+1.
  - sext sign-extends the 2N-bit prod to ACC_W+1 bits.
  - The sum is formed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If clamping occurs, ovf_sticky <= 1.
  - Accumulation continues from the clamped value.
- Accepting the TERMS-th product (count==TERMS-1) moves the state to DONE and clears count to 0.
- DONE: out_valid=1, in_ready=0. result=acc and ovf=ovf_sticky, both held stable until the handshake.
- In DONE, out_valid && out_ready moves the state to ACCUM and sets acc <= 0, ovf_sticky <= 0. No input is accepted in that same cycle.
- clear=1 in ACCUM: acc <= 0, count <= 0, ovf_sticky <= 0. Any simultaneous input is dropped; in_ready stays 1, but clear has priority over accept.
- clear=1 in DONE is ignored. A pending result is never discarded by clear.
- Reset asserted mid-sum or in DONE: all state returns to reset values immediately. The partial sum or pending result is lost.
- Reset values: in_ready=1, out_valid=0, result=0, ovf=0.
- Outputs are driven from registers and state only; there is no combinational path from out_ready or in_valid to any output.

## Timing
- Each accepted product updates acc on the same clock edge (1-cycle add).
- out_valid rises on the clock edge that accepts the last term. The result is visible in the next cycle.
- Minimum period per result is TERMS+1 cycles: TERMS accepts plus one DONE cycle, with out_ready held high.
- in_valid may toggle freely between terms. Gaps do not disturb acc or count.
- Backpressure: DONE persists indefinitely while out_ready=0. in_ready stays 0 throughout.
- result and ovf do not change while out_valid=1.

## Test plan
- **Basic sum.** Defaults. Reset, then stream prod 0x03, 0xFE, 0x05, 0x01 back-to-back. Required: out_valid one cycle after the 4th accept, result=12'h007, ovf=0.
- **Negative sum with gaps.** Stream 0xC8 (-56), idle 2 cycles, 0xC8, 0xC8, 0xC8. Required: result=12'hF20 (-224), ovf=0, no extra terms counted.
- **Saturation.** ACC_W=8, TERMS=4. Stream 0x40 four times. Required: result=8'h7F, ovf=1. The next result (4x 0x01) must be 8'h04 with ovf=0.
- **Backpressure.** out_ready=0 for 5 cycles after DONE while in_valid=1. Required: in_ready=0, result stable, no input consumed. Release out_ready: one handshake, then in_ready=1 the next cycle.
- **Clear.** After 2 terms (0x05, 0x05), assert clear together with in_valid and prod 0x7F. Then stream 0x01 x4. Required: result=12'h004, ovf=0.
- **Async reset.** Assert rst_n=0 mid-sum (after 3 terms) and separately while in DONE. Required: outputs drop to reset values without waiting for a clock edge. A following 4-term stream of 0x02 gives result=12'h008.

Source files
------------

// File: rtl/product_accumulator.sv
// Saturating accumulate stage: sums TERMS signed products from the multiplier
// and presents each dot-product result with a sticky overflow flag.
module product_accumulator #(
  parameter int N     = 4,
  parameter int TERMS = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2*N-1:0]   prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_t;

  localparam logic [7:0]       LAST    = 8'(TERMS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_count;
  logic             r_ovf;

  logic [ACC_W:0]   w_sum;
  logic             w_pos_ovf;
  logic             w_neg_ovf;
  logic [ACC_W-1:0] w_sat;
  logic             w_accept;
  logic             w_last;

  // Sum at ACC_W+1 bits; the top two bits disagreeing means the result left range.
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-2*N){prod[2*N-1]}}, prod};
  assign w_pos_ovf = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
  assign w_neg_ovf =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
  assign w_sat     = w_pos_ovf ? ACC_MAX : (w_neg_ovf ? ACC_MIN : w_sum[ACC_W-1:0]);

  assign w_accept  = (r_state == S_ACCUM) && in_valid && !clear;
  assign w_last    = (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: if (w_accept && w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready)          w_state_next = S_ACCUM;
      default: w_state_next = S_ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_ACCUM);
    out_valid = (r_state == S_DONE);
    result    = r_acc;
    ovf       = r_ovf;
  end

  // Clear only acts in ACCUM, so a pending result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_ACCUM) begin
      if (clear) begin
        r_acc   <= '0;
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (in_valid) begin
        r_acc   <= w_sat;
        r_ovf   <= r_ovf | w_pos_ovf | w_neg_ovf;
        r_count <= w_last ? 8'd0 : r_count + 8'd1;
      end
    end else if (out_ready) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: default instance plus an 8-bit
// accumulator instance for saturation.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  prod = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clear = 1'b0;
  logic [11:0] result;
  logic        ovf;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [7:0]  s_prod = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic        s_clear = 1'b0;
  logic [7:0]  s_result;
  logic        s_ovf;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;

  product_accumulator #(.N(4), .TERMS(4), .ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .prod(prod), .in_valid(in_valid), .in_ready(in_ready),
    .clear(clear), .result(result), .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  product_accumulator #(.N(4), .TERMS(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .prod(s_prod), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .clear(s_clear), .result(s_result), .ovf(s_ovf), .out_valid(s_out_valid),
    .out_ready(s_out_ready)
  );

  typedef struct packed {
    logic [11:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb8[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: plain integer running sum clamped after each term.
  function automatic exp_t model(input byte p[4], input int accw);
    int   acc = 0;
    int   mx  = (1 << (accw - 1)) - 1;
    int   mn  = -(1 << (accw - 1));
    exp_t e;
    e.ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = acc + int'(p[i]);
      if (acc > mx) begin acc = mx; e.ovf = 1'b1; end
      if (acc < mn) begin acc = mn; e.ovf = 1'b1; end
    end
    e.res = 12'(acc);
    return e;
  endfunction

  // Present one product and hold it until the edge that accepts it.
  task automatic drive(input logic [7:0] p);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    prod     = p;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (result !== 12'h000)  begin errors++; $display("FAIL reset_result got=%h exp=000", result); end
    checks++; if (ovf !== 1'b0)        begin errors++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    exp_t e;
    bit   ok;
    sb.push_back(exp_t'{res: 12'h007, ovf: 1'b0});
    drive(8'h03); drive(8'hFE); drive(8'h05); drive(8'h01);
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid=%0b exp=1", out_valid); end
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL basic_in_ready got=%0b exp=0", in_ready); end
    idle();
    wait_ov(ok);
    e = sb.pop_front();
    checks++; if (!ok)               begin errors++; $display("FAIL basic_timeout out_valid=0 exp=1"); end
    checks++; if (result !== e.res)  begin errors++; $display("FAIL basic_result got=%h exp=%h", result, e.res); end
    checks++; if (ovf !== e.ovf)     begin errors++; $display("FAIL basic_ovf got=%0b exp=%0b", ovf, e.ovf); end
    handshake();
    $display("test_basic result=%h ovf=%0b", result, ovf);
  endtask

  task automatic test_gaps();
    exp_t e;
    bit   ok;
    sb.push_back(exp_t'{res: 12'hF20, ovf: 1'b0});
    drive(8'hC8);
    idle();
    @(negedge clk);
    checks++; if (result !== 12'hFC8) begin errors++; $display("FAIL gaps_partial got=%h exp=fc8", result); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early_valid got=%0b exp=0", out_valid); end
    drive(8'hC8); drive(8'hC8); drive(8'hC8);
    idle();
    wait_ov(ok);
    e = sb.pop_front();
    checks++; if (!ok)              begin errors++; $display("FAIL gaps_timeout out_valid=0 exp=1"); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL gaps_result got=%h exp=%h", result, e.res); end
    checks++; if (ovf !== e.ovf)    begin errors++; $display("FAIL gaps_ovf got=%0b exp=%0b", ovf, e.ovf); end
    handshake();
    $display("test_gaps done");
  endtask

  task automatic test_saturation();
    exp_t e;
    sb8.push_back(exp_t'{res: 12'h07F, ovf: 1'b1});
    sb8.push_back(exp_t'{res: 12'h004, ovf: 1'b0});
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        s_in_valid = 1'b1;
        s_prod     = (r == 0) ? 8'h40 : 8'h01;
        @(posedge clk);
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      e = sb8.pop_front();
      checks++; if (s_out_valid !== 1'b1)     begin errors++; $display("FAIL sat%0d_valid got=%0b exp=1", r, s_out_valid); end
      checks++; if (s_result !== e.res[7:0])  begin errors++; $display("FAIL sat%0d_result got=%h exp=%h", r, s_result, e.res[7:0]); end
      checks++; if (s_ovf !== e.ovf)          begin errors++; $display("FAIL sat%0d_ovf got=%0b exp=%0b", r, s_ovf, e.ovf); end
      s_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_out_ready = 1'b0;
      $display("test_saturation result%0d=%h ovf=%0b", r, e.res[7:0], e.ovf);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    sb.push_back(exp_t'{res: 12'h0A0, ovf: 1'b0});
    drive(8'h10); drive(8'h20); drive(8'h30); drive(8'h40);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      prod = 8'h11;
      checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b exp=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%0b exp=1", i, out_valid); end
      checks++; if (result !== e.res)   begin errors++; $display("FAIL bp_result[%0d] got=%h exp=%h", i, result, e.res); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL bp_consumed result=%h exp=000", result); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_clear();
    exp_t e;
    bit   ok;
    drive(8'h05); drive(8'h05);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    prod     = 8'h7F;
    @(posedge clk);
    #1;
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL clear_acc got=%h exp=000", result); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL clear_in_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    sb.push_back(exp_t'{res: 12'h004, ovf: 1'b0});
    for (int i = 0; i < 4; i++) drive(8'h01);
    idle();
    wait_ov(ok);
    e = sb.pop_front();
    checks++; if (!ok)              begin errors++; $display("FAIL clear_timeout out_valid=0 exp=1"); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL clear_result got=%h exp=%h", result, e.res); end
    checks++; if (ovf !== e.ovf)    begin errors++; $display("FAIL clear_ovf got=%0b exp=%0b", ovf, e.ovf); end
    handshake();
    $display("test_clear done");
  endtask

  task automatic test_async_reset();
    exp_t e;
    bit   ok;
    for (int i = 0; i < 3; i++) drive(8'h05);
    idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL arst_mid_result got=%h exp=000", result); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_mid_in_ready got=%0b exp=1", in_ready); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'h07);
    idle();
    wait_ov(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_done_timeout out_valid=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_done_valid got=%0b exp=0", out_valid); end
    checks++; if (result !== 12'h000) begin errors++; $display("FAIL arst_done_result got=%h exp=000", result); end
    checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL arst_done_ovf got=%0b exp=0", ovf); end
    #1 rst_n = 1'b1;
    sb.push_back(exp_t'{res: 12'h008, ovf: 1'b0});
    for (int i = 0; i < 4; i++) drive(8'h02);
    idle();
    wait_ov(ok);
    e = sb.pop_front();
    checks++; if (!ok)              begin errors++; $display("FAIL arst_after_timeout out_valid=0 exp=1"); end
    checks++; if (result !== e.res) begin errors++; $display("FAIL arst_after_result got=%h exp=%h", result, e.res); end
    handshake();
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    byte    a[4];
    byte    b[4];
    logic [7:0] seq[8];
    time    t_first = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = byte'($urandom_range(0, 255));
      b[i] = byte'($urandom_range(0, 255));
      seq[i]     = a[i];
      seq[i + 4] = b[i];
    end
    sb.push_back(model(a, 12));
    sb.push_back(model(b, 12));
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) drive(seq[k]);
        idle();
      end
      begin
        for (int r = 0; r < 2; r++) begin
          exp_t e;
          bit   ok = 1'b0;
          for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
          end
          e = sb.pop_front();
          checks++; if (!ok)              begin errors++; $display("FAIL b2b%0d_timeout out_valid=0 exp=1", r); end
          checks++; if (result !== e.res) begin errors++; $display("FAIL b2b%0d_result got=%h exp=%h", r, result, e.res); end
          checks++; if (ovf !== e.ovf)    begin errors++; $display("FAIL b2b%0d_ovf got=%0b exp=%0b", r, ovf, e.ovf); end
          $display("test_back_to_back result%0d=%h exp=%h", r, result, e.res);
          if (r == 0) t_first = $time;
          else begin
            checks++;
            if ($time - t_first != 50) begin
              errors++;
              $display("FAIL b2b_period got=%0t exp=50", $time - t_first);
            end
          end
          @(posedge clk);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
